// File: rtl/oric_kbd_pkg.sv
// oric_kbd_pkg: shared types and constants for the Oric keyboard matrix block.
//   key_pos_t : lookup result {valid, nmi, row[2:0], col[2:0]}
//   SC_*      : PS/2 set-2 scan codes of every mapped key (arrows are E0-extended)
//   ROW_*/COL_* : matrix coordinates of the arrow, space and shift cells
package oric_kbd_pkg;

    typedef struct packed {
        logic       valid;  // code maps to a matrix cell
        logic       nmi;    // code is the NMI ("reset button") key
        logic [2:0] row;
        logic [2:0] col;
    } key_pos_t;

    localparam key_pos_t KEY_NONE = '0;
    localparam key_pos_t KEY_NMI  = '{valid: 1'b0, nmi: 1'b1, row: 3'd0, col: 3'd0};

    // Digits
    localparam logic [7:0] SC_1 = 8'h16, SC_2 = 8'h1E, SC_3 = 8'h26, SC_4 = 8'h25;
    localparam logic [7:0] SC_5 = 8'h2E, SC_6 = 8'h36, SC_7 = 8'h3D, SC_8 = 8'h3E;
    localparam logic [7:0] SC_9 = 8'h46, SC_0 = 8'h45;
    // Letters
    localparam logic [7:0] SC_A = 8'h1C, SC_B = 8'h32, SC_C = 8'h21, SC_D = 8'h23;
    localparam logic [7:0] SC_E = 8'h24, SC_F = 8'h2B, SC_G = 8'h34, SC_H = 8'h33;
    localparam logic [7:0] SC_I = 8'h43, SC_J = 8'h3B, SC_K = 8'h42, SC_L = 8'h4B;
    localparam logic [7:0] SC_M = 8'h3A, SC_N = 8'h31, SC_O = 8'h44, SC_P = 8'h4D;
    localparam logic [7:0] SC_Q = 8'h15, SC_R = 8'h2D, SC_S = 8'h1B, SC_T = 8'h2C;
    localparam logic [7:0] SC_U = 8'h3C, SC_V = 8'h2A, SC_W = 8'h1D, SC_X = 8'h22;
    localparam logic [7:0] SC_Y = 8'h35, SC_Z = 8'h1A;
    // Punctuation and control keys
    localparam logic [7:0] SC_SPACE = 8'h29, SC_COMMA = 8'h41, SC_PERIOD = 8'h49;
    localparam logic [7:0] SC_SLASH = 8'h4A, SC_SEMI = 8'h4C, SC_QUOTE = 8'h52;
    localparam logic [7:0] SC_MINUS = 8'h4E, SC_EQUAL = 8'h55, SC_LBRACKET = 8'h54;
    localparam logic [7:0] SC_RBRACKET = 8'h5B, SC_BSLASH = 8'h5D, SC_ENTER = 8'h5A;
    localparam logic [7:0] SC_BKSP = 8'h66, SC_ESC = 8'h76, SC_LSHIFT = 8'h12;
    localparam logic [7:0] SC_RSHIFT = 8'h59, SC_LCTRL = 8'h14, SC_LALT = 8'h11;
    localparam logic [7:0] SC_F11 = 8'h78;
    // E0-extended arrows
    localparam logic [7:0] SC_UP = 8'h75, SC_DOWN = 8'h72, SC_LEFT = 8'h6B, SC_RIGHT = 8'h74;

    // Row 4 carries space, left shift and the four arrows (also the joystick cells)
    localparam logic [2:0] ROW_ARROW  = 3'd4;
    localparam logic [2:0] COL_SPACE  = 3'd0;
    localparam logic [2:0] COL_UP     = 3'd3;
    localparam logic [2:0] COL_LSHIFT = 3'd4;
    localparam logic [2:0] COL_LEFT   = 3'd5;
    localparam logic [2:0] COL_DOWN   = 3'd6;
    localparam logic [2:0] COL_RIGHT  = 3'd7;
    localparam logic [2:0] ROW_RSHIFT = 3'd7;
    localparam logic [2:0] COL_RSHIFT = 3'd4;

    function automatic key_pos_t key_at(input logic [2:0] row, input logic [2:0] col);
        key_pos_t p;
        p.valid = 1'b1;
        p.nmi   = 1'b0;
        p.row   = row;
        p.col   = col;
        return p;
    endfunction

endpackage

// File: rtl/oric_kbd_matrix_if.sv
// oric_kbd_matrix_if: host-side bundle of the keyboard matrix block.
//   ps2_key  : hps_io key event word {toggle, pressed, ext, code[7:0]}
//   row_sel  : VIA PB[2:0] row select;  col_mask : PSG port A, 0 selects a column
//   joy      : joystick word (only when ORIC_KBD_JOY_EN is defined)
//   key_sense, nmi_req, any_key : results back to the host
// master = driver of the query/event side, slave = the matrix block.
interface oric_kbd_matrix_if;
    logic [10:0] ps2_key;
    logic [2:0]  row_sel;
    logic [7:0]  col_mask;
`ifdef ORIC_KBD_JOY_EN
    logic [15:0] joy;
`endif
    logic        key_sense;
    logic        nmi_req;
    logic        any_key;

`ifdef ORIC_KBD_JOY_EN
    modport master (output ps2_key, row_sel, col_mask, joy,
                    input  key_sense, nmi_req, any_key);
    modport slave  (input  ps2_key, row_sel, col_mask, joy,
                    output key_sense, nmi_req, any_key);
`else
    modport master (output ps2_key, row_sel, col_mask,
                    input  key_sense, nmi_req, any_key);
    modport slave  (input  ps2_key, row_sel, col_mask,
                    output key_sense, nmi_req, any_key);
`endif
endinterface

// File: rtl/oric_scancode_lut.sv
// oric_scancode_lut: combinational ROM from a PS/2 set-2 key {ext, code} to its
// Oric matrix cell. F11 reports nmi instead of a cell; anything else unmapped
// returns all-zero.
//   ext  : E0-extended flag
//   code : scan code
//   pos  : {valid, nmi, row, col}
module oric_scancode_lut
    import oric_kbd_pkg::*;
(
    input  logic       ext,
    input  logic [7:0] code,
    output key_pos_t   pos
);

    always_comb begin
        pos = KEY_NONE;
        case ({ext, code})
            // Row 0
            {1'b0, SC_7}:        pos = key_at(3'd0, 3'd0);
            {1'b0, SC_N}:        pos = key_at(3'd0, 3'd1);
            {1'b0, SC_5}:        pos = key_at(3'd0, 3'd2);
            {1'b0, SC_V}:        pos = key_at(3'd0, 3'd3);
            {1'b0, SC_1}:        pos = key_at(3'd0, 3'd5);
            {1'b0, SC_X}:        pos = key_at(3'd0, 3'd6);
            {1'b0, SC_3}:        pos = key_at(3'd0, 3'd7);
            // Row 1
            {1'b0, SC_J}:        pos = key_at(3'd1, 3'd0);
            {1'b0, SC_T}:        pos = key_at(3'd1, 3'd1);
            {1'b0, SC_R}:        pos = key_at(3'd1, 3'd2);
            {1'b0, SC_F}:        pos = key_at(3'd1, 3'd3);
            {1'b0, SC_ESC}:      pos = key_at(3'd1, 3'd5);
            {1'b0, SC_Q}:        pos = key_at(3'd1, 3'd6);
            {1'b0, SC_D}:        pos = key_at(3'd1, 3'd7);
            // Row 2
            {1'b0, SC_M}:        pos = key_at(3'd2, 3'd0);
            {1'b0, SC_6}:        pos = key_at(3'd2, 3'd1);
            {1'b0, SC_B}:        pos = key_at(3'd2, 3'd2);
            {1'b0, SC_4}:        pos = key_at(3'd2, 3'd3);
            {1'b0, SC_LCTRL}:    pos = key_at(3'd2, 3'd4);
            {1'b0, SC_Z}:        pos = key_at(3'd2, 3'd5);
            {1'b0, SC_2}:        pos = key_at(3'd2, 3'd6);
            {1'b0, SC_C}:        pos = key_at(3'd2, 3'd7);
            // Row 3
            {1'b0, SC_K}:        pos = key_at(3'd3, 3'd0);
            {1'b0, SC_9}:        pos = key_at(3'd3, 3'd1);
            {1'b0, SC_SEMI}:     pos = key_at(3'd3, 3'd2);
            {1'b0, SC_MINUS}:    pos = key_at(3'd3, 3'd3);
            {1'b0, SC_BSLASH}:   pos = key_at(3'd3, 3'd6);
            {1'b0, SC_QUOTE}:    pos = key_at(3'd3, 3'd7);
            // Row 4: space, shift and arrows
            {1'b0, SC_SPACE}:    pos = key_at(ROW_ARROW, COL_SPACE);
            {1'b0, SC_COMMA}:    pos = key_at(ROW_ARROW, 3'd1);
            {1'b0, SC_PERIOD}:   pos = key_at(ROW_ARROW, 3'd2);
            {1'b1, SC_UP}:       pos = key_at(ROW_ARROW, COL_UP);
            {1'b0, SC_LSHIFT}:   pos = key_at(ROW_ARROW, COL_LSHIFT);
            {1'b1, SC_LEFT}:     pos = key_at(ROW_ARROW, COL_LEFT);
            {1'b1, SC_DOWN}:     pos = key_at(ROW_ARROW, COL_DOWN);
            {1'b1, SC_RIGHT}:    pos = key_at(ROW_ARROW, COL_RIGHT);
            // Row 5 (left Alt stands in for FUNCT)
            {1'b0, SC_U}:        pos = key_at(3'd5, 3'd0);
            {1'b0, SC_I}:        pos = key_at(3'd5, 3'd1);
            {1'b0, SC_O}:        pos = key_at(3'd5, 3'd2);
            {1'b0, SC_P}:        pos = key_at(3'd5, 3'd3);
            {1'b0, SC_LALT}:     pos = key_at(3'd5, 3'd4);
            {1'b0, SC_BKSP}:     pos = key_at(3'd5, 3'd5);
            {1'b0, SC_RBRACKET}: pos = key_at(3'd5, 3'd6);
            {1'b0, SC_LBRACKET}: pos = key_at(3'd5, 3'd7);
            // Row 6
            {1'b0, SC_Y}:        pos = key_at(3'd6, 3'd0);
            {1'b0, SC_H}:        pos = key_at(3'd6, 3'd1);
            {1'b0, SC_G}:        pos = key_at(3'd6, 3'd2);
            {1'b0, SC_E}:        pos = key_at(3'd6, 3'd3);
            {1'b0, SC_A}:        pos = key_at(3'd6, 3'd5);
            {1'b0, SC_S}:        pos = key_at(3'd6, 3'd6);
            {1'b0, SC_W}:        pos = key_at(3'd6, 3'd7);
            // Row 7
            {1'b0, SC_8}:        pos = key_at(3'd7, 3'd0);
            {1'b0, SC_L}:        pos = key_at(3'd7, 3'd1);
            {1'b0, SC_0}:        pos = key_at(3'd7, 3'd2);
            {1'b0, SC_SLASH}:    pos = key_at(3'd7, 3'd3);
            {1'b0, SC_RSHIFT}:   pos = key_at(ROW_RSHIFT, COL_RSHIFT);
            {1'b0, SC_ENTER}:    pos = key_at(3'd7, 3'd5);
            {1'b0, SC_EQUAL}:    pos = key_at(3'd7, 3'd7);
            // NMI button
            {1'b0, SC_F11}:      pos = KEY_NMI;
            default:             pos = KEY_NONE;
        endcase
    end

endmodule

// File: rtl/oric_kbd_matrix.sv
// oric_kbd_matrix: turns hps_io PS/2 key events into the Oric 8x8 keyboard
// matrix and answers the VIA/PSG row/column sense query.
//   clk_sys : system clock (rising edge)
//   reset   : synchronous, active-high
//   bus     : oric_kbd_matrix_if.slave (ps2_key, row_sel, col_mask, [joy] in;
//             key_sense, nmi_req, any_key out)
// Parameter NMI_PULSE_CYCLES (>=1, fits 15 bits): nmi_req pulse length.
// Optional macro ORIC_KBD_JOY_EN: joystick Right/Left/Down/Up/Fire overlaid
// onto the arrow and space cells of row 4 at the sense stage.
// Pipeline: edge detect + capture (stage 1), lookup + matrix write (stage 2),
// registered sense/any_key.
module oric_kbd_matrix
    import oric_kbd_pkg::*;
#(
    parameter int unsigned NMI_PULSE_CYCLES = 16384
) (
    input logic               clk_sys,
    input logic               reset,
    oric_kbd_matrix_if.slave  bus
);

    localparam logic [14:0] NmiLoad = 15'(NMI_PULSE_CYCLES);

    logic             strobe_q;
    logic             key_event;
    logic             s1_valid_q;
    logic             s1_pressed_q;
    logic             s1_ext_q;
    logic [7:0]       s1_code_q;
    key_pos_t         pos;
    logic [7:0][7:0]  matrix_q;   // [row][col]
    logic [14:0]      nmi_cnt_q;
    logic             key_sense_q;
    logic             any_key_q;
    logic [7:0]       joy_row;
    logic             joy_any;
    logic [7:0]       eff_row;

    assign key_event = bus.ps2_key[10] ^ strobe_q;

    // Stage 1: capture the event word
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            strobe_q     <= 1'b0;
            s1_valid_q   <= 1'b0;
            s1_pressed_q <= 1'b0;
            s1_ext_q     <= 1'b0;
            s1_code_q    <= 8'h00;
        end else begin
            strobe_q   <= bus.ps2_key[10];
            s1_valid_q <= key_event;
            if (key_event) begin
                {s1_pressed_q, s1_ext_q, s1_code_q} <= bus.ps2_key[9:0];
            end
        end
    end

    oric_scancode_lut u_lut (
        .ext  (s1_ext_q),
        .code (s1_code_q),
        .pos  (pos)
    );

    // Stage 2: matrix write; re-writing the same value makes typematic repeats harmless
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            matrix_q <= '0;
        end else if (s1_valid_q && pos.valid) begin
            matrix_q[pos.row][pos.col] <= s1_pressed_q;
        end
    end

    // NMI pulse: a fresh press reloads, so a press during the pulse extends it
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            nmi_cnt_q <= 15'd0;
        end else if (s1_valid_q && pos.nmi && s1_pressed_q) begin
            nmi_cnt_q <= NmiLoad;
        end else if (nmi_cnt_q != 15'd0) begin
            nmi_cnt_q <= nmi_cnt_q - 15'd1;
        end
    end

`ifdef ORIC_KBD_JOY_EN
    logic [4:0] joy_q;
    logic       joy_unused;

    assign joy_unused = ^bus.joy[15:5];

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            joy_q <= 5'd0;
        end else begin
            joy_q <= bus.joy[4:0];
        end
    end

    // Joystick only affects the sensed view; the matrix itself is never written
    always_comb begin
        joy_row = 8'h00;
        if (bus.row_sel == ROW_ARROW) begin
            joy_row[COL_RIGHT] = joy_q[0];
            joy_row[COL_LEFT]  = joy_q[1];
            joy_row[COL_DOWN]  = joy_q[2];
            joy_row[COL_UP]    = joy_q[3];
            joy_row[COL_SPACE] = joy_q[4];
        end
    end
    assign joy_any = |joy_q;
`else
    assign joy_row = 8'h00;
    assign joy_any = 1'b0;
`endif

    assign eff_row = matrix_q[bus.row_sel] | joy_row;

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            key_sense_q <= 1'b0;
            any_key_q   <= 1'b0;
        end else begin
            key_sense_q <= |(eff_row & ~bus.col_mask);
            any_key_q   <= (|matrix_q) | joy_any;
        end
    end

    assign bus.key_sense = key_sense_q;
    assign bus.any_key   = any_key_q;
    assign bus.nmi_req   = (nmi_cnt_q != 15'd0);

endmodule

// File: doc/oric_kbd_matrix.md
# oric_kbd_matrix

Converts the PS/2 key-event word from `hps_io` into the Oric's 8×8 keyboard matrix state. It answers the row/column sense query that the `oricatmos` core makes through the VIA port B and the PSG I/O port. It sits directly upstream of `oricatmos`, replacing the raw `key_code`/`key_strobe` hookup, and also generates the NMI ("reset button") request from a function key.

## Interface
Parameters:
- `NMI_PULSE_CYCLES`, default 16384: length of the `nmi_req` pulse in `clk_sys` cycles; must be ≥1.

Ports:
- `clk_sys`  in  1  system clock. One clock; all logic is on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `ps2_key`  in  11  bit [10] toggles once per event; [9] pressed (1) / released (0); [8] E0-extended; [7:0] scan code.
- `row_sel`  in  3  matrix row selected by VIA PB[2:0].
- `col_mask`  in  8  PSG port A column mask; a 0 bit selects that column.
- `joy`  in  16  MiSTer joystick word. Present only with `ORIC_KBD_JOY_EN`.
- `key_sense`  out  1  to VIA PB3; 1 when any pressed key lies in the selected row under a 0 column bit.
- `nmi_req`  out  1  active-high NMI request pulse.
- `any_key`  out  1  1 while any matrix bit is set (LED/debug use).

## Operation
- Event detect: `strobe_q` holds `ps2_key[10]` from the previous cycle. An event is `ps2_key[10] ^ strobe_q`. `strobe_q` resets to 0.
- Stage 1, capture: on an event, register {pressed, ext, code} and set `s1_valid`. Otherwise `s1_valid` is 0.
- Stage 2, lookup and write: `oric_scancode_lut` maps {ext, code} to {valid, nmi, row[2:0], col[2:0]}.
  - valid: `matrix[row][col] <= pressed`.
  - nmi with pressed=1: load the NMI counter. Release of the NMI key is ignored.
  - Unmapped codes are ignored.
- Required mappings (row, col):
  - A 0x1C → (6,5)
  - Space 0x29 → (4,0)
  - L-Shift 0x12 → (4,4)
  - R-Shift 0x59 → (7,4)
  - E0 75 Up → (4,3)
  - E0 72 Down → (4,6)
  - E0 6B Left → (4,5)
  - E0 74 Right → (4,7)
  - F11 0x78 → NMI
  - The full table lives in the package.
- Sense: `key_sense <= |(eff_row & ~col_mask)`, where `eff_row = matrix[row_sel]`, OR'd with the joystick contribution when that feature is compiled in.
- NMI: a 15-bit down-counter loads `NMI_PULSE_CYCLES` and decrements to 0. `nmi_req = (count != 0)`. A new F11 press while counting reloads the counter, extending the pulse.
- `any_key = |matrix`, registered.
- Repeated press events, such as PS/2 typematic repeats, are idempotent.

## Timing
- Reset values:
  - `matrix` all 0
  - `s1_valid` 0
  - NMI counter 0
  - `key_sense` 0
  - `nmi_req` 0
  - `any_key` 0
- Latency:
  - Toggle seen at cycle N → `matrix` bit updated at edge N+2 → `key_sense`/`any_key` reflect it at edge N+3.
  - `row_sel`/`col_mask` change at N → `key_sense` valid at N+1.
- Throughput: one event per cycle. Toggles in consecutive cycles are each processed in order; the later event wins on the same cell.
- Press and release of the same key on consecutive cycles: the cell ends at 0.
- `reset` mid-pipeline: the in-flight event is dropped, the matrix is cleared and an NMI pulse is cut off. `strobe_q` reloads to 0, so if `ps2_key[10]`=1 at reset release, one spurious event is decoded. That event is harmless because it re-applies the last key state.
- F11 press at N → `nmi_req` high from edge N+2 for exactly `NMI_PULSE_CYCLES` cycles.

## Configuration
- `ORIC_KBD_JOY_EN` defined:
  - `joy` port exists and is registered once (`joy_q`).
  - `joy_q` bits [0] Right, [1] Left, [2] Down, [3] Up, [4] Fire are OR'd into cells (4,7), (4,5), (4,6), (4,3), (4,0) respectively at the sense stage and into `any_key`.
  - Joystick latency is 2 cycles to `key_sense`.
  - Joystick input never writes `matrix`.
- Undefined: no `joy` port, no `joy_q`; behaviour is keyboard-only.

## Structure
- Package `oric_kbd_pkg`:
  - `typedef key_pos_t` {valid, nmi, row[2:0], col[2:0]}
  - scan-code constants for all mapped keys
  - row/column localparams for the arrow, space and shift cells
- Sub-module `oric_scancode_lut`: purely combinational case-ROM from {ext, code[7:0]} to `key_pos_t`.
- Top level holds the edge detect, both pipeline stages, the matrix, the sense register and the NMI counter.

## Test plan
- Toggle `ps2_key`={1,1,0,0x1C}, then set `row_sel`=6, `col_mask`=8'hDF → `key_sense`=1 at N+3. Then `col_mask`=8'hFF → `key_sense`=0 one cycle later.
- Press E0 75, then release E0 75 on the next cycle, with `row_sel`=4, `col_mask`=8'hF7 → `key_sense` ends at 0 and `any_key` ends at 0.
- Press L-Shift and R-Shift, then release L-Shift → `row_sel`=4 with `col_mask`=8'hEF gives 0; `row_sel`=7 with `col_mask`=8'hEF gives 1.
- F11 press with `NMI_PULSE_CYCLES`=16 → `nmi_req` high for exactly 16 cycles. A second press at cycle 10 of the pulse extends it to 26 total.
- Press Space, then assert `reset` for 1 cycle → matrix cleared, `key_sense`=0 and `any_key`=0 on the cycle after reset.
- With `ORIC_KBD_JOY_EN`: `joy`=16'h0010, `row_sel`=4, `col_mask`=8'hFE → `key_sense`=1 two cycles later while `matrix` stays 0.
